// File: rtl/tamagotchi_pkg.sv
// rtl/tamagotchi_pkg.sv - shared button indices, hold-timer states and helpers for the pet front end
// Contents:
//   BTN_* localparams  index of each raw button in raw_btn
//   NUM_BTN / NUM_ACT  total buttons / action buttons (the low NUM_ACT indices)
//   hold_state_t       hold timer states IDLE, COUNT, DONE
//   first_one()        keeps only the lowest set bit (lowest index = highest priority)
package tamagotchi_pkg;

    localparam int BTN_SALUD     = 0;
    localparam int BTN_ENERGIA   = 1;
    localparam int BTN_HAMBRE    = 2;
    localparam int BTN_DIVERSION = 3;
    localparam int BTN_RESET     = 4;
    localparam int BTN_TEST      = 5;
    localparam int NUM_BTN       = 6;
    localparam int NUM_ACT       = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } hold_state_t;

    function automatic logic [NUM_ACT-1:0] first_one(input logic [NUM_ACT-1:0] v);
        return v & (~v + NUM_ACT'(1));
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - one-button 2-FF synchroniser, debounce and rise detect
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   raw    in   raw asynchronous button level
//   level  out  debounced level (1 = pressed)
//   rise   out  high for the one cycle after level goes 0->1 (combinational)
// Parameters:
//   DB_CYC          consecutive disagreeing cycles before the debounced level flips (>= 1)
//   BTN_ACTIVE_LOW  1 = invert raw before synchronising
module btn_debounce #(
    parameter int DB_CYC         = 4,
    parameter bit BTN_ACTIVE_LOW = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CNT_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

    logic             sync1;
    logic             sync2;
    logic             level_q;
    logic             level_d1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            level_q  <= 1'b0;
            level_d1 <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= raw ^ BTN_ACTIVE_LOW;
            sync2    <= sync1;
            level_d1 <= level_q;
            // cnt holds the number of disagreeing cycles already seen; the
            // DB_CYC-th one flips the level so the flip lands 2+DB_CYC cycles
            // after a clean raw edge.
            if (sync2 != level_q) begin
                if (cnt == CNT_W'(DB_CYC - 1)) begin
                    level_q <= sync2;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign level = level_q;
    assign rise  = level_q & ~level_d1;

endmodule

// File: rtl/tamagotchi_btn_conditioner.sv
// rtl/tamagotchi_btn_conditioner.sv - button front end: debounce, action pulses, reset/test hold timers
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   raw_btn[5:0]   in   [0]salud [1]energia [2]hambre [3]diversion [4]reset [5]test, asynchronous
//   btn_salud      out  one-cycle press pulse (same for energia, hambre, diversion; at most one-hot)
//   btn_reset      out  one-cycle pulse once reset has been held HOLD_S seconds
//   btn_test       out  one-cycle pulse once test has been held HOLD_S seconds
//   count_reset    out  whole seconds reset held, saturating at HOLD_S
//   count_test     out  whole seconds test held, saturating at HOLD_S
// Build option: define AUTO_REPEAT_EN to auto-repeat held action buttons
//   (first repeat REPEAT_DLY_MS after the press pulse, then every REPEAT_MS).
module tamagotchi_btn_conditioner
    import tamagotchi_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int DEBOUNCE_MS    = 20,
    parameter int HOLD_S         = 5,
    parameter int BTN_ACTIVE_LOW = 0,
    parameter int REPEAT_DLY_MS  = 500,
    parameter int REPEAT_MS      = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] raw_btn,
    output logic               btn_salud,
    output logic               btn_energia,
    output logic               btn_hambre,
    output logic               btn_diversion,
    output logic               btn_reset,
    output logic               btn_test,
    output logic [2:0]         count_reset,
    output logic [2:0]         count_test
);

    localparam int CYC_PER_S = CLK_HZ;
    localparam int CYC_W     = (CYC_PER_S > 1) ? $clog2(CYC_PER_S) : 1;
    localparam int DB_RAW    = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int DB_CYC    = (DB_RAW > 0) ? DB_RAW : 1;
    localparam int RPT_D_RAW = CLK_HZ / 1000 * REPEAT_DLY_MS;
    localparam int RPT_P_RAW = CLK_HZ / 1000 * REPEAT_MS;
    localparam logic [31:0] RPT_DLY_CYC = 32'((RPT_D_RAW > 0) ? RPT_D_RAW : 1);
    localparam logic [31:0] RPT_CYC     = 32'((RPT_P_RAW > 0) ? RPT_P_RAW : 1);

`ifdef AUTO_REPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] rise;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
        btn_debounce #(
            .DB_CYC        (DB_CYC),
            .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW != 0)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_btn[g]),
            .level(level[g]),
            .rise (rise[g])
        );
    end

    // ------------------------------------------------------------------
    // Auto-repeat: one timer, owned by the highest-priority held action
    // button. Ownership change reloads the first delay; the request lands
    // in the same candidate vector as fresh presses.
    // ------------------------------------------------------------------
    logic [NUM_ACT-1:0] owner;
    logic [NUM_ACT-1:0] rpt_owner_q;
    logic [31:0]        rpt_cnt_q;
    logic [NUM_ACT-1:0] rpt_req;

    assign owner = first_one(level[NUM_ACT-1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_owner_q <= '0;
            rpt_cnt_q   <= '0;
        end else if (owner != rpt_owner_q) begin
            rpt_owner_q <= owner;
            rpt_cnt_q   <= RPT_DLY_CYC;
        end else if (owner != '0) begin
            if (rpt_cnt_q <= 32'd1) begin
                rpt_cnt_q <= RPT_CYC;
            end else begin
                rpt_cnt_q <= rpt_cnt_q - 32'd1;
            end
        end
    end

    assign rpt_req = (RPT_EN && owner != '0 && owner == rpt_owner_q && rpt_cnt_q == 32'd1)
                   ? owner : '0;

    // ------------------------------------------------------------------
    // Action pulses: priority-select, suppressed while reset/test held.
    // ------------------------------------------------------------------
    logic [NUM_ACT-1:0] act_cand;
    logic [NUM_ACT-1:0] act_d;
    logic [NUM_ACT-1:0] act_q;

    assign act_cand = rise[NUM_ACT-1:0] | rpt_req;
    assign act_d    = (level[BTN_RESET] || level[BTN_TEST]) ? '0 : first_one(act_cand);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q <= '0;
        end else begin
            act_q <= act_d;
        end
    end

    assign btn_salud     = act_q[BTN_SALUD];
    assign btn_energia   = act_q[BTN_ENERGIA];
    assign btn_hambre    = act_q[BTN_HAMBRE];
    assign btn_diversion = act_q[BTN_DIVERSION];

    // ------------------------------------------------------------------
    // Hold timers: index 0 = reset, 1 = test.
    // ------------------------------------------------------------------
    logic [1:0]       hold_lvl;
    logic [1:0]       hold_rise;
    logic [1:0]       hold_kill;
    hold_state_t      st_q  [2];
    hold_state_t      st_d  [2];
    logic [CYC_W-1:0] cyc_q [2];
    logic [CYC_W-1:0] cyc_d [2];
    logic [2:0]       sec_q [2];
    logic [2:0]       sec_d [2];
    logic [1:0]       fire_d;
    logic [1:0]       fire_q;

    assign hold_lvl  = {level[BTN_TEST], level[BTN_RESET]};
    assign hold_rise = {rise[BTN_TEST], rise[BTN_RESET]};
    // Test is held in IDLE while reset is down; because IDLE only leaves on a
    // rise, test stays idle after reset releases until it is pressed again.
    assign hold_kill = {level[BTN_RESET], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= IDLE;
                cyc_q[i] <= '0;
                sec_q[i] <= '0;
            end
            fire_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= st_d[i];
                cyc_q[i] <= cyc_d[i];
                sec_q[i] <= sec_d[i];
            end
            fire_q <= fire_d;
        end
    end

    always_comb begin
        fire_d = '0;
        for (int i = 0; i < 2; i++) begin
            st_d[i]  = st_q[i];
            cyc_d[i] = cyc_q[i];
            sec_d[i] = sec_q[i];
            if (!hold_lvl[i] || hold_kill[i]) begin
                st_d[i]  = IDLE;
                cyc_d[i] = '0;
                sec_d[i] = '0;
            end else begin
                case (st_q[i])
                    IDLE: begin
                        if (hold_rise[i]) begin
                            st_d[i]  = COUNT;
                            cyc_d[i] = '0;
                            sec_d[i] = '0;
                        end
                    end
                    COUNT: begin
                        if (cyc_q[i] == CYC_W'(CYC_PER_S - 1)) begin
                            cyc_d[i] = '0;
                            sec_d[i] = sec_q[i] + 3'd1;
                            if (sec_q[i] + 3'd1 == 3'(HOLD_S)) begin
                                st_d[i]   = DONE;
                                fire_d[i] = 1'b1;
                            end
                        end else begin
                            cyc_d[i] = cyc_q[i] + CYC_W'(1);
                        end
                    end
                    DONE: begin
                        sec_d[i] = 3'(HOLD_S);
                    end
                    default: begin
                        st_d[i]  = IDLE;
                        cyc_d[i] = '0;
                        sec_d[i] = '0;
                    end
                endcase
            end
        end
    end

    assign btn_reset   = fire_q[0];
    assign btn_test    = fire_q[1];
    assign count_reset = sec_q[0];
    assign count_test  = sec_q[1];

endmodule

// File: tb/tb_tamagotchi_btn_conditioner.sv
// tb/tb_tamagotchi_btn_conditioner.sv - self-checking bench for tamagotchi_btn_conditioner
module tb_tamagotchi_btn_conditioner;

    localparam int CLK_HZ = 1000;
    localparam int DB     = 4;
    localparam int HOLD   = 5;
    localparam int SEC    = CLK_HZ;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] raw_btn = 6'd0;
    logic       btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test;
    logic [2:0] count_reset, count_test;

    always #5 clk = ~clk;

    tamagotchi_btn_conditioner #(
        .CLK_HZ        (CLK_HZ),
        .DEBOUNCE_MS   (4),
        .HOLD_S        (HOLD),
        .BTN_ACTIVE_LOW(0),
        .REPEAT_DLY_MS (500),
        .REPEAT_MS     (200)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .raw_btn      (raw_btn),
        .btn_salud    (btn_salud),
        .btn_energia  (btn_energia),
        .btn_hambre   (btn_hambre),
        .btn_diversion(btn_diversion),
        .btn_reset    (btn_reset),
        .btn_test     (btn_test),
        .count_reset  (count_reset),
        .count_test   (count_test)
    );

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int   n_edge = 0;
    bit   m_p1[6], m_p2[6], m_db[6], rise_prev[6], lvl_prev[6];
    int   run[6];
    bit   h_act[2];
    int   h_start[2];
    logic [3:0] e_act;
    logic       e_br, e_bt;
    logic [2:0] e_cr, e_ct;

    // scenario statistics
    int pulses[4];
    int br_cnt, bt_cnt, max_cr, max_ct, salud_at, br_at, tick_i;

    task automatic model_step(input logic [5:0] r, input logic rr);
        logic [3:0] cand;
        bit         kill;
        int         el;
        int         secs;
        n_edge++;
        if (rr) begin
            for (int b = 0; b < 6; b++) begin
                m_p1[b] = 0; m_p2[b] = 0; m_db[b] = 0; run[b] = 0;
                rise_prev[b] = 0; lvl_prev[b] = 0;
            end
            h_act[0] = 0; h_act[1] = 0;
            e_act = '0; e_br = 0; e_bt = 0; e_cr = '0; e_ct = '0;
            return;
        end
        // registered outputs derive from the levels/rises seen last cycle
        for (int i = 0; i < 4; i++) cand[i] = rise_prev[i];
        if (lvl_prev[4] || lvl_prev[5]) cand = '0;
        e_act = '0;
        for (int i = 0; i < 4; i++) begin
            if (cand[i]) begin
                e_act[i] = 1'b1;
                break;
            end
        end
        for (int h = 0; h < 2; h++) begin
            kill = !lvl_prev[4 + h] || (h == 1 && lvl_prev[4]);
            if (kill) h_act[h] = 0;
            else if (!h_act[h] && rise_prev[4 + h]) begin
                h_act[h]   = 1;
                h_start[h] = n_edge;
            end
            el   = n_edge - h_start[h];
            secs = h_act[h] ? ((el / SEC > HOLD) ? HOLD : el / SEC) : 0;
            if (h == 0) begin
                e_cr = 3'(secs);
                e_br = h_act[h] && (el == HOLD * SEC);
            end else begin
                e_ct = 3'(secs);
                e_bt = h_act[h] && (el == HOLD * SEC);
            end
        end
        // debounce: level flips after DB consecutive disagreeing synced samples
        for (int b = 0; b < 6; b++) begin
            bit s;
            bit old;
            s = m_p2[b];
            m_p2[b] = m_p1[b];
            m_p1[b] = r[b];
            old = m_db[b];
            if (s != m_db[b]) begin
                run[b]++;
                if (run[b] == DB) begin
                    m_db[b] = !m_db[b];
                    run[b]  = 0;
                end
            end else begin
                run[b] = 0;
            end
            rise_prev[b] = m_db[b] && !old;
            lvl_prev[b]  = m_db[b];
        end
    endtask

    task automatic clr_stats();
        for (int i = 0; i < 4; i++) pulses[i] = 0;
        br_cnt = 0; bt_cnt = 0; max_cr = 0; max_ct = 0; salud_at = -1; br_at = -1;
    endtask

    task automatic tick(input int cycles, input string tag);
        logic [3:0] obs;
        for (tick_i = 1; tick_i <= cycles; tick_i++) begin
            @(posedge clk);
            model_step(raw_btn, rst);
            #1;
            obs = {btn_diversion, btn_hambre, btn_energia, btn_salud};
            vectors++;
            if ({obs, btn_reset, btn_test, count_reset, count_test} !== {e_act, e_br, e_bt, e_cr, e_ct}) begin
                miscompares++;
                $display("FAIL %s edge%0d: got act=%b br=%b bt=%b cr=%0d ct=%0d, want act=%b br=%b bt=%b cr=%0d ct=%0d",
                         tag, n_edge, obs, btn_reset, btn_test, count_reset, count_test,
                         e_act, e_br, e_bt, e_cr, e_ct);
            end
            for (int j = 0; j < 4; j++) if (obs[j]) pulses[j]++;
            if (btn_salud && salud_at < 0) salud_at = tick_i;
            if (btn_reset) begin br_cnt++; if (br_at < 0) br_at = tick_i; end
            if (btn_test) bt_cnt++;
            if (int'(count_reset) > max_cr) max_cr = int'(count_reset);
            if (int'(count_test) > max_ct) max_ct = int'(count_test);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test, count_reset, count_test} !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_async: got %b, want all zero",
                     {btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test, count_reset, count_test});
        end
        tick(3, "reset");
        rst = 1'b0;
        tick(5, "reset_release");
    endtask

    task automatic test_glitch_salud();
        clr_stats();
        for (int k = 0; k < 10; k++) begin
            raw_btn[0] = (k % 2 == 0);
            tick(2, "glitch");
        end
        vectors++;
        if (pulses[0] != 0) begin
            miscompares++;
            $display("FAIL glitch_no_pulse: got %0d pulses, want 0", pulses[0]);
        end
        raw_btn[0] = 1'b1;
        clr_stats();
        tick(15, "salud_press");
        vectors++;
        if (pulses[0] != 1 || salud_at != 2 + DB + 1) begin
            miscompares++;
            $display("FAIL salud_latency: got %0d pulses at cycle %0d, want 1 at %0d", pulses[0], salud_at, 2 + DB + 1);
        end
        raw_btn[0] = 1'b0;
        clr_stats();
        tick(15, "salud_release");
        vectors++;
        if (pulses[0] != 0) begin
            miscompares++;
            $display("FAIL release_no_pulse: got %0d, want 0", pulses[0]);
        end
    endtask

    task automatic test_short_energia();
        clr_stats();
        raw_btn[1] = 1'b1;
        tick(3, "energia_short");
        raw_btn[1] = 1'b0;
        tick(15, "energia_short");
        vectors++;
        if (pulses[1] != 0) begin
            miscompares++;
            $display("FAIL energia_short: got %0d pulses, want 0", pulses[1]);
        end
    endtask

    task automatic test_hold_full();
        clr_stats();
        raw_btn[4] = 1'b1;
        tick(5200, "reset_hold");
        vectors++;
        if (br_cnt != 1 || br_at != 2 + DB + 1 + HOLD * SEC || max_cr != HOLD || count_reset !== 3'(HOLD)) begin
            miscompares++;
            $display("FAIL reset_hold: got pulses=%0d at=%0d max=%0d now=%0d, want 1 at %0d max=%0d now=%0d",
                     br_cnt, br_at, max_cr, count_reset, 2 + DB + 1 + HOLD * SEC, HOLD, HOLD);
        end
        raw_btn[4] = 1'b0;
        tick(2 + DB + 1, "reset_release");
        vectors++;
        if (count_reset !== 3'd0 || br_cnt != 1) begin
            miscompares++;
            $display("FAIL reset_release: got count=%0d pulses=%0d, want 0 and 1", count_reset, br_cnt);
        end
        tick(5, "reset_idle");
    endtask

    task automatic test_hold_short();
        clr_stats();
        raw_btn[4] = 1'b1;
        tick(3500, "reset_short");
        raw_btn[4] = 1'b0;
        tick(12, "reset_short_rel");
        vectors++;
        if (max_cr != 3 || br_cnt != 0 || count_reset !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_short: got max=%0d pulses=%0d now=%0d, want 3 0 0", max_cr, br_cnt, count_reset);
        end
    endtask

    task automatic test_priority();
        clr_stats();
        raw_btn = 6'b000101;
        tick(12, "salud_hambre");
        vectors++;
        if (pulses[0] != 1 || pulses[2] != 0) begin
            miscompares++;
            $display("FAIL priority: got salud=%0d hambre=%0d, want 1 0", pulses[0], pulses[2]);
        end
        raw_btn = 6'b0;
        tick(12, "prio_release");
        clr_stats();
        raw_btn[5] = 1'b1;
        tick(12, "test_held");
        raw_btn[2] = 1'b1;
        tick(12, "hambre_during_test");
        vectors++;
        if (pulses[2] != 0) begin
            miscompares++;
            $display("FAIL suppress: got hambre=%0d, want 0", pulses[2]);
        end
        raw_btn = 6'b0;
        tick(12, "suppress_release");
    endtask

    task automatic test_rst_midhold();
        clr_stats();
        raw_btn[5] = 1'b1;
        tick(2500, "test_hold");
        vectors++;
        if (count_test !== 3'd2) begin
            miscompares++;
            $display("FAIL test_hold_count: got %0d, want 2", count_test);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test, count_reset, count_test} !== 12'd0) begin
            miscompares++;
            $display("FAIL rst_midhold: got %b, want all zero",
                     {btn_salud, btn_energia, btn_hambre, btn_diversion, btn_reset, btn_test, count_reset, count_test});
        end
        tick(1, "rst_pulse");
        rst = 1'b0;
        clr_stats();
        tick(1100, "test_restart");
        vectors++;
        if (max_ct != 1 || count_test !== 3'd1) begin
            miscompares++;
            $display("FAIL test_restart: got max=%0d now=%0d, want 1 1", max_ct, count_test);
        end
        raw_btn[5] = 1'b0;
        tick(12, "test_release");
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int k = 0; k < 80; k++) begin
            r = $urandom;
            raw_btn = r[5:0] & (r[9:8] == 2'b00 ? 6'h3f : 6'h0f);
            tick($urandom_range(1, 30), "random");
        end
        raw_btn = 6'b0;
        tick(15, "random_settle");
    endtask

    initial begin
        clr_stats();
        test_reset();
        test_glitch_salud();
        test_short_energia();
        test_hold_full();
        test_hold_short();
        test_priority();
        test_rst_midhold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
